load_store_unit: RTL and testbench

//  Memory-access stage between execute and the register file. Accepts one load/store per

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/load_store_unit_if.sv | 60 ++++++
 rtl/load_store_unit_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// rv_lsu_pkg
// Shared definitions for the load/store unit: datapath widths, RV32I funct3
// encodings for memory accesses, and the LSU control state type.
// No ports (package).
// -----------------------------------------------------------------------------
package rv_lsu_pkg;

    localparam int XLEN   = 32;  // datapath width; only 32 is supported
    localparam int ADDR_W = 32;  // byte-address width

    // RV32I funct3 for loads; stores reuse F3_B/F3_H/F3_W.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RSP = 3'd2,
        WB       = 3'd3,
        ERR      = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// lsu_req_if : execute-stage side of the LSU.
//   master (execute)  drives req_valid/req_is_store/req_funct3/req_addr/
//                     req_wdata/req_rd; observes req_ready, wb_valid/wb_rd/
//                     wb_data, lsu_err, busy.
//   slave  (LSU)      the mirror image.
// lsu_mem_if : data-memory side of the LSU.
//   master (LSU)      drives mem_req_valid/mem_we/mem_addr/mem_wdata/mem_wstrb;
//                     observes mem_req_ready, mem_rsp_valid, mem_rdata.
//   slave  (memory)   the mirror image.
// -----------------------------------------------------------------------------
interface lsu_req_if;
    import rv_lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              lsu_err;
    logic              busy;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready, wb_valid, wb_rd, wb_data, lsu_err, busy
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready, wb_valid, wb_rd, wb_data, lsu_err, busy
    );
endinterface

interface lsu_mem_if;
    import rv_lsu_pkg::*;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// -----------------------------------------------------------------------------
// lsu_align : combinational lane logic for the LSU.
//   is_store    in   1     access is a store
//   funct3      in   3     RV32I memory funct3
//   offset      in   2     byte offset within the word (addr[1:0])
//   store_data  in   XLEN  store data (rs2)
//   load_word   in   XLEN  raw word returned by memory
//   lane_wdata  out  XLEN  store data replicated across lanes
//   lane_wstrb  out  4     byte enables for stores (0 for loads)
//   load_data   out  XLEN  load data shifted down and sign/zero extended
//   illegal     out  1     misaligned access or unsupported funct3
// -----------------------------------------------------------------------------
module lsu_align
    import rv_lsu_pkg::*;
(
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [XLEN-1:0] lane_wdata,
    output logic [3:0]      lane_wstrb,
    output logic [XLEN-1:0] load_data,
    output logic            illegal
);

    logic [XLEN-1:0] shifted;

    // Store lanes and legality.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        lane_wdata = store_data;
        lane_wstrb = 4'b0000;
        illegal    = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    lane_wstrb = 4'b0001 << offset;
                    lane_wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    lane_wstrb = 4'b0011 << {offset[1], 1'b0};
                    lane_wdata = {2{store_data[15:0]}};
                    illegal    = offset[0];
                end
                F3_W: begin
                    lane_wstrb = 4'b1111;
                    illegal    = |offset;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: illegal = 1'b0;
                F3_H, F3_HU: illegal = offset[0];
                F3_W:        illegal = |offset;
                default:     illegal = 1'b1;
            endcase
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit : memory-access stage between execute and the register file.
// One load/store in flight. Requests are accepted only in IDLE, issued to data
// memory with a valid/ready handshake, and loads return a one-cycle writeback.
//   clk   in  1            rising-edge clock
//   rst   in  1            synchronous reset, active-high
//   req   lsu_req_if.slave execute request, writeback, lsu_err, busy
//   mem   lsu_mem_if.master data-memory request and response
// All outputs are registered; req_ready is 1 in IDLE and busy is 1 elsewhere.
// -----------------------------------------------------------------------------
module load_store_unit
    import rv_lsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    lsu_state_t state;

    // Fields of the accepted request still needed after the accept edge.
    // Address and store data live on in the registered mem_* outputs.
    logic       cap_is_store;
    logic [2:0] cap_funct3;
    logic [1:0] cap_offset;
    logic [4:0] cap_rd;

    // The aligner looks at the live request while IDLE (to build the memory
    // request) and at the captured request afterwards (to extract load data).
    logic            sel_is_store;
    logic [2:0]      sel_funct3;
    logic [1:0]      sel_offset;
    logic [XLEN-1:0] lane_wdata;
    logic [3:0]      lane_wstrb;
    logic [XLEN-1:0] load_data;
    logic            illegal;

    assign sel_is_store = (state == IDLE) ? req.req_is_store  : cap_is_store;
    assign sel_funct3   = (state == IDLE) ? req.req_funct3    : cap_funct3;
    assign sel_offset   = (state == IDLE) ? req.req_addr[1:0] : cap_offset;

    lsu_align u_align (
        .is_store   (sel_is_store),
        .funct3     (sel_funct3),
        .offset     (sel_offset),
        .store_data (req.req_wdata),
        .load_word  (mem.mem_rdata),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .load_data  (load_data),
        .illegal    (illegal)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cap_is_store      <= 1'b0;
            cap_funct3        <= 3'b000;
            cap_offset        <= 2'b00;
            cap_rd            <= 5'd0;
            req.req_ready     <= 1'b1;
            req.busy          <= 1'b0;
            req.lsu_err       <= 1'b0;
            req.wb_valid      <= 1'b0;
            req.wb_rd         <= 5'd0;
            req.wb_data       <= '0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_we        <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            mem.mem_wstrb     <= 4'b0000;
        end else begin
            // Single-cycle pulses default low; wb_rd/wb_data hold.
            req.lsu_err  <= 1'b0;
            req.wb_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        cap_is_store  <= req.req_is_store;
                        cap_funct3    <= req.req_funct3;
                        cap_offset    <= req.req_addr[1:0];
                        cap_rd        <= req.req_rd;
                        req.req_ready <= 1'b0;
                        req.busy      <= 1'b1;
                        if (illegal) begin
                            state       <= ERR;
                            req.lsu_err <= 1'b1;
                        end else begin
                            state             <= REQ;
                            mem.mem_req_valid <= 1'b1;
                            mem.mem_we        <= req.req_is_store;
                            mem.mem_addr      <= {req.req_addr[ADDR_W-1:2], 2'b00};
                            mem.mem_wdata     <= lane_wdata;
                            mem.mem_wstrb     <= req.req_is_store ? lane_wstrb : 4'b0000;
                        end
                    end
                end

                REQ: begin
                    if (mem.mem_req_ready) begin
                        mem.mem_req_valid <= 1'b0;
                        if (cap_is_store) begin
                            state         <= IDLE;
                            req.req_ready <= 1'b1;
                            req.busy      <= 1'b0;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end
                end

                WAIT_RSP: begin
                    if (mem.mem_rsp_valid) begin
                        state        <= WB;
                        // x0 is never written, but rd/data are still presented.
                        req.wb_valid <= (cap_rd != 5'd0);
                        req.wb_rd    <= cap_rd;
                        req.wb_data  <= load_data;
                    end
                end

                WB, ERR: begin
                    state         <= IDLE;
                    req.req_ready <= 1'b1;
                    req.busy      <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    req.req_ready <= 1'b1;
                    req.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit : self-checking bench for load_store_unit.
// Directed scenarios followed by randomized accesses; expected values come
// from an arithmetic model of the access rules (sizes, lanes, extension).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lsu_req_if req_bus ();
    lsu_mem_if mem_bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .req (req_bus),
        .mem (mem_bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Access size in bytes, 0 for an unsupported funct3.
    function automatic int access_size(input bit st, input logic [2:0] f3);
        if (st) begin
            if (f3 == 3'd0) return 1;
            if (f3 == 3'd1) return 2;
            if (f3 == 3'd2) return 4;
            return 0;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    function automatic bit model_illegal(input bit st, input logic [2:0] f3, input int off);
        int sz;
        sz = access_size(st, f3);
        return (sz == 0) || ((off % sz) != 0);
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input int off);
        int sz;
        sz = access_size(1'b1, f3);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        int sz;
        sz = access_size(1'b1, f3);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [31:0] word);
        logic [31:0] v;
        int sz;
        sz = access_size(1'b0, f3);
        v  = word >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Change request inputs arbitrarily while the LSU is busy.
    task automatic scramble();
        req_bus.req_valid    = 1'($urandom_range(0, 1));
        req_bus.req_is_store = 1'($urandom_range(0, 1));
        req_bus.req_funct3   = 3'($urandom_range(0, 7));
        req_bus.req_addr     = $urandom;
        req_bus.req_wdata    = $urandom;
        req_bus.req_rd       = 5'($urandom_range(0, 31));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_bus.req_ready, 1);
        check({tag, "_busy"}, req_bus.busy, 0);
        check({tag, "_lsu_err"}, req_bus.lsu_err, 0);
        check({tag, "_wb_valid"}, req_bus.wb_valid, 0);
        check({tag, "_wb_rd"}, req_bus.wb_rd, 0);
        check({tag, "_wb_data"}, req_bus.wb_data, 0);
        check({tag, "_mem_req_valid"}, mem_bus.mem_req_valid, 0);
        check({tag, "_mem_we"}, mem_bus.mem_we, 0);
        check({tag, "_mem_addr"}, mem_bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_bus.mem_wdata, 0);
        check({tag, "_mem_wstrb"}, mem_bus.mem_wstrb, 0);
    endtask

    // One complete access. Called with the LSU idle, just after a clock edge.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd,
                             input logic [31:0] rdata, input int stall, input int rsp_dly);
        int off;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        off      = int'(addr[1:0]);
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_wdata = model_wdata(f3, wdata);
        exp_load  = model_load(f3, off, rdata);

        check("idle_req_ready", req_bus.req_ready, 1);
        check("idle_busy", req_bus.busy, 0);

        req_bus.req_valid    = 1'b1;
        req_bus.req_is_store = st;
        req_bus.req_funct3   = f3;
        req_bus.req_addr     = addr;
        req_bus.req_wdata    = wdata;
        req_bus.req_rd       = rd;
        tick();
        scramble();

        if (model_illegal(st, f3, off)) begin
            check("err_pulse", req_bus.lsu_err, 1);
            check("err_no_mem", mem_bus.mem_req_valid, 0);
            check("err_req_ready", req_bus.req_ready, 0);
            tick();
            req_bus.req_valid = 1'b0;
            check("err_pulse_end", req_bus.lsu_err, 0);
            check("err_no_mem2", mem_bus.mem_req_valid, 0);
            check("err_no_wb", req_bus.wb_valid, 0);
            check("err_ready_back", req_bus.req_ready, 1);
            return;
        end

        check("req_valid", mem_bus.mem_req_valid, 1);
        check("req_addr", mem_bus.mem_addr, exp_addr);
        check("req_we", mem_bus.mem_we, st);
        check("req_wstrb", mem_bus.mem_wstrb, st ? model_wstrb(f3, off) : 4'b0000);
        check("req_no_err", req_bus.lsu_err, 0);
        if (st) check("req_wdata", mem_bus.mem_wdata, exp_wdata);

        for (int i = 0; i < stall; i++) begin
            mem_bus.mem_req_ready = 1'b0;
            tick();
            scramble();
            check("stall_valid", mem_bus.mem_req_valid, 1);
            check("stall_addr", mem_bus.mem_addr, exp_addr);
            check("stall_req_ready", req_bus.req_ready, 0);
            check("stall_busy", req_bus.busy, 1);
            if (st) check("stall_wdata", mem_bus.mem_wdata, exp_wdata);
        end

        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        scramble();
        check("hs_valid_drop", mem_bus.mem_req_valid, 0);
        check("hs_no_wb", req_bus.wb_valid, 0);

        if (st) begin
            req_bus.req_valid = 1'b0;
            check("st_ready_back", req_bus.req_ready, 1);
            check("st_busy_clear", req_bus.busy, 0);
            return;
        end

        check("ld_busy", req_bus.busy, 1);
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            check("wait_no_wb", req_bus.wb_valid, 0);
        end

        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = rdata;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rdata     = $urandom;
        check("wb_valid", req_bus.wb_valid, (rd != 5'd0) ? 1 : 0);
        check("wb_rd", req_bus.wb_rd, rd);
        check("wb_data", req_bus.wb_data, exp_load);
        check("wb_req_ready", req_bus.req_ready, 0);

        tick();
        req_bus.req_valid = 1'b0;
        check("wb_pulse_end", req_bus.wb_valid, 0);
        check("wb_data_hold", req_bus.wb_data, exp_load);
        check("ld_ready_back", req_bus.req_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        req_bus.req_valid     = 1'b0;
        req_bus.req_is_store  = 1'b0;
        req_bus.req_funct3    = 3'b000;
        req_bus.req_addr      = '0;
        req_bus.req_wdata     = '0;
        req_bus.req_rd        = 5'd0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rdata     = '0;

        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Aligned word load, zero-wait memory.
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0);
        // Byte/half loads with sign and zero extension.
        do_access(1'b0, 3'b000, 32'h13, 32'h0, 5'd6, 32'h8011_2233, 0, 0);
        do_access(1'b0, 3'b100, 32'h13, 32'h0, 5'd7, 32'h8011_2233, 0, 0);
        do_access(1'b0, 3'b001, 32'h12, 32'h0, 5'd8, 32'h8011_2233, 0, 0);
        // Half store into upper lanes.
        do_access(1'b1, 3'b001, 32'h06, 32'h0000_ABCD, 5'd9, 32'h0, 0, 0);
        // Misaligned word load.
        do_access(1'b0, 3'b010, 32'h02, 32'h0, 5'd3, 32'h0, 0, 0);
        // Word store held off by memory for 5 cycles.
        do_access(1'b1, 3'b010, 32'h40, 32'h1234_5678, 5'd0, 32'h0, 5, 0);
        // Illegal funct3 values.
        do_access(1'b0, 3'b011, 32'h20, 32'h0, 5'd4, 32'h0, 0, 0);
        do_access(1'b1, 3'b100, 32'h20, 32'h0, 5'd4, 32'h0, 0, 0);

        // Reset while waiting for a load response; late response is dropped.
        req_bus.req_valid    = 1'b1;
        req_bus.req_is_store = 1'b0;
        req_bus.req_funct3   = 3'b010;
        req_bus.req_addr     = 32'h20;
        req_bus.req_rd       = 5'd7;
        tick();
        req_bus.req_valid     = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        check("abort_busy", req_bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = 32'hCAFE_F00D;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check("late_rsp_no_wb", req_bus.wb_valid, 0);
        check("late_rsp_idle", req_bus.busy, 0);
        tick();
        check("late_rsp_no_wb2", req_bus.wb_valid, 0);

        // Load to x0 never raises wb_valid.
        do_access(1'b0, 3'b010, 32'h30, 32'h0, 5'd0, 32'h5555_AAAA, 0, 0);

        // Randomized accesses with random memory back-pressure and latency.
        for (int n = 0; n < 60; n++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, 5'($urandom_range(0, 31)), $urandom,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
